// File: rtl/fifo_rd_drain_if.sv
// Downstream valid/ready word stream leaving the FIFO read-side drain controller.
interface fifo_rd_drain_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_drain.sv
// FIFO read-side drain controller: issues rd_en, captures one-cycle-latency read
// data into a 2-entry skid buffer and presents it on a valid/ready stream.
module fifo_rd_drain #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             clr_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_error_i,
  output logic             fifo_rd_en_o,
  fifo_rd_drain_if.master  m_if,
  output logic             busy_o,
  output logic [CNT_W-1:0] words_o,
  output logic             err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       occ_q, occ_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             err_q, err_d;

  logic             pop;
  logic             push;
  logic             rd_en;
  logic [2:0]       fill;

  assign pop  = (occ_q != 2'd0) && m_if.m_ready;
  assign push = pend_q && !fifo_error_i;

  // Buffer slots committed after this cycle, counting the in-flight read.
  assign fill  = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign rd_en = (state_q == RUN) && !fifo_empty_i && (fill < 3'd2);

  // Next-state for the run/drain state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      // A read issued this very cycle still counts as in flight, so it is drained.
      RUN:     if (!enable_i)
                 state_d = ((occ_q != 2'd0) || pend_q || rd_en) ? DRAIN : IDLE;
      DRAIN:   if (enable_i) state_d = RUN;
               else if ((occ_q == 2'd0) && !pend_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer update: head is buf0, tail is buf1; push lands behind any remaining word.
  always_comb begin
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    pend_d = rd_en;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    if (pop) begin
      if (occ_q == 2'd2) buf0_d = buf1_q;
      else if (push)     buf0_d = fifo_rdata_i;
      if (push && (occ_q == 2'd2)) buf1_d = fifo_rdata_i;
    end else if (push) begin
      if (occ_q == 2'd0) buf0_d = fifo_rdata_i;
      else               buf1_d = fifo_rdata_i;
    end
  end

  // Delivered-word counter and sticky error; clear has priority.
  always_comb begin
    words_d = words_q;
    err_d   = err_q;
    if (clr_i) begin
      words_d = '0;
      err_d   = 1'b0;
    end else begin
      if (pop && (words_q != '1)) words_d = words_q + CNT_W'(1);
      if (pend_q && fifo_error_i) err_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      occ_q   <= 2'd0;
      pend_q  <= 1'b0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      words_q <= words_d;
      err_q   <= err_d;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_if.m_valid = (occ_q != 2'd0);
  assign m_if.m_data  = buf0_q;
  assign busy_o       = (state_q != IDLE);
  assign words_o      = words_q;
  assign err_o        = err_q;

endmodule
